segment_scan_rx: RTL

Receive side of the multiplexed seven-segment display path: samples the segment bus and one-hot digit-select strobes driven to a 4-digit display and reconstructs the 6-bit character code shown on each digit. Each digit has a stability filter, so a code commits only after a configurable run of identical samples, plus an optional scan watchdog. It sits in self-test and loopback builds beside the display drivers, letting a bench or on-chip checker read back what the panel actually shows.

---
 rtl/segment_scan_rx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/segment_scan_rx.sv
// -----------------------------------------------------------------------------
// segment_scan_rx
// Readback receiver for a multiplexed 4-digit seven-segment display. It watches
// the segment bus and the one-hot digit strobes, filters each digit's pattern
// through a run-length stability filter, and decodes committed glyphs back to
// the 6-bit character codes 'h00-'h23 (0-9, A-Z).
//
// Optional feature: define SEGMENT_SCAN_RX_TIMEOUT_EN to add a per-digit scan
// watchdog that drops o_vld[d] after p_timeout cycles without selection.
// Without the macro p_timeout is ignored and valids stay set until reset/clear.
//
// Parameters
//   p_stable   identical samples of a digit needed to commit (>= 1)
//   p_timeout  unselected cycles before a digit's valid drops (watchdog only)
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous reset, active low
//   i_dig       one-hot digit select
//   i_sgmnt     segment pattern, bit0 = a ... bit6 = g, active-high lit
//   i_clr       synchronous clear of all state, wins over a same-cycle sample
//   o_val       committed code per digit
//   o_vld       per-digit committed-code valid
//   o_err       per-digit: last committed pattern is not a legal glyph
//   o_upd       one-cycle pulse when a commit changed a digit's visible state
//   o_scan_err  sticky: a select with more than one bit set was seen
// -----------------------------------------------------------------------------
module segment_scan_rx #(
   parameter int p_stable  = 4,
   parameter int p_timeout = 1_000_000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [3:0]      i_dig,
   input  logic [6:0]      i_sgmnt,
   input  logic            i_clr,
   output logic [3:0][5:0] o_val,
   output logic [3:0]      o_vld,
   output logic [3:0]      o_err,
   output logic            o_upd,
   output logic            o_scan_err
);

   localparam int CW = $clog2(p_stable + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(p_stable);
   localparam logic [CW-1:0] CNT_PRE = CW'(p_stable - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if (p_stable < 1 || p_timeout < 1) begin : g_bad_param
      $error("segment_scan_rx: p_stable and p_timeout must be >= 1");
   end

   // Character font shared with the display encoder: code -> segment pattern.
   // Several letters reuse a digit glyph (O=0, S=5, Z=2, X=H).
   function automatic logic [6:0] seg_font(input logic [5:0] code);
      case (code)
         6'd0:  return 7'h3F;  6'd1:  return 7'h06;  6'd2:  return 7'h5B;
         6'd3:  return 7'h4F;  6'd4:  return 7'h66;  6'd5:  return 7'h6D;
         6'd6:  return 7'h7D;  6'd7:  return 7'h07;  6'd8:  return 7'h7F;
         6'd9:  return 7'h6F;  6'd10: return 7'h77;  6'd11: return 7'h7C;
         6'd12: return 7'h39;  6'd13: return 7'h5E;  6'd14: return 7'h79;
         6'd15: return 7'h71;  6'd16: return 7'h3D;  6'd17: return 7'h76;
         6'd18: return 7'h30;  6'd19: return 7'h1E;  6'd20: return 7'h75;
         6'd21: return 7'h38;  6'd22: return 7'h37;  6'd23: return 7'h54;
         6'd24: return 7'h3F;  6'd25: return 7'h73;  6'd26: return 7'h67;
         6'd27: return 7'h50;  6'd28: return 7'h6D;  6'd29: return 7'h78;
         6'd30: return 7'h3E;  6'd31: return 7'h1C;  6'd32: return 7'h2A;
         6'd33: return 7'h76;  6'd34: return 7'h6E;  6'd35: return 7'h5B;
         default: return 7'h00;
      endcase
   endfunction

   // Inverse font: returns {legal, code}. Scanning from the top down lets the
   // lowest matching code win for shared glyphs. A blank pattern is never legal.
   function automatic logic [6:0] seg_decode(input logic [6:0] pat);
      logic [6:0] r;
      r = 7'h00;
      for (int c = 35; c >= 0; c--) begin
         if (pat != 7'h00 && seg_font(6'(c)) == pat) r = {1'b1, 6'(c)};
      end
      return r;
   endfunction

   logic [6:0]    cand [4];
   logic [CW-1:0] cnt  [4];

   logic       multi;
   logic [6:0] dec;
   logic [3:0] hit, same, commit, chg;

`ifdef SEGMENT_SCAN_RX_TIMEOUT_EN
   localparam int TW = $clog2(p_timeout + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(p_timeout);
   localparam logic [TW-1:0] TO_PRE = TW'(p_timeout - 1);
   localparam logic [TW-1:0] TO_ONE = TW'(1);

   logic [TW-1:0] idle [4];
   logic [3:0]    to_hit;
`endif

   always_comb begin
      // x & (x-1) is nonzero exactly when two or more bits are set.
      multi  = |(i_dig & (i_dig - 4'd1));
      dec    = seg_decode(i_sgmnt);
      hit    = '0;
      same   = '0;
      commit = '0;
      chg    = '0;
      for (int d = 0; d < 4; d++) begin
         hit[d]    = i_dig[d] & ~multi;
         same[d]   = (i_sgmnt == cand[d]);
         // A new pattern starts its run at 1, so it commits at once when p_stable is 1.
         commit[d] = hit[d] & (same[d] ? (cnt[d] == CNT_PRE) : (p_stable == 1));
         chg[d]    = commit[d] & (~o_vld[d] |
                                  (dec[6] ? ((dec[5:0] != o_val[d]) | o_err[d]) : ~o_err[d]));
      end
   end

`ifdef SEGMENT_SCAN_RX_TIMEOUT_EN
   always_comb begin
      to_hit = '0;
      for (int d = 0; d < 4; d++) begin
         to_hit[d] = ~hit[d] & (idle[d] == TO_PRE);
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_val      <= '0;
         o_vld      <= '0;
         o_err      <= '0;
         o_upd      <= 1'b0;
         o_scan_err <= 1'b0;
         for (int d = 0; d < 4; d++) begin
            cand[d] <= '0;
            cnt[d]  <= '0;
`ifdef SEGMENT_SCAN_RX_TIMEOUT_EN
            idle[d] <= '0;
`endif
         end
      end else if (i_clr) begin
         o_val      <= '0;
         o_vld      <= '0;
         o_err      <= '0;
         o_upd      <= 1'b0;
         o_scan_err <= 1'b0;
         for (int d = 0; d < 4; d++) begin
            cand[d] <= '0;
            cnt[d]  <= '0;
`ifdef SEGMENT_SCAN_RX_TIMEOUT_EN
            idle[d] <= '0;
`endif
         end
      end else begin
         o_upd <= |chg;
         if (multi) o_scan_err <= 1'b1;
         for (int d = 0; d < 4; d++) begin
            if (hit[d]) begin
               if (!same[d]) begin
                  cand[d] <= i_sgmnt;
                  cnt[d]  <= CNT_ONE;
               end else if (cnt[d] != CNT_MAX) begin
                  cnt[d]  <= cnt[d] + CNT_ONE;
               end
               if (commit[d]) begin
                  o_vld[d] <= 1'b1;
                  if (dec[6]) begin
                     o_val[d] <= dec[5:0];
                     o_err[d] <= 1'b0;
                  end else begin
                     o_err[d] <= 1'b1;
                  end
               end
            end
`ifdef SEGMENT_SCAN_RX_TIMEOUT_EN
            if (hit[d]) begin
               idle[d] <= '0;
            end else if (idle[d] != TO_MAX) begin
               idle[d] <= idle[d] + TO_ONE;
            end
            // Starved digit: drop valid and restart its run, keep the last code.
            if (to_hit[d]) begin
               o_vld[d] <= 1'b0;
               cnt[d]   <= '0;
            end
`endif
         end
      end
   end

endmodule
